// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter
//   Merges two register-file writeback requesters into a single registered
//   write port. Each requester has a one-entry holding buffer. One full
//   buffer is granted per cycle, and the grant is driven to the bank on the
//   following cycle. Writes to register 0 are accepted and take their
//   arbitration slot, but they never pulse RegWrite.
//
//   Arbitration:
//     default               round-robin between A and B (1-bit FSM)
//     WB_STRICT_PRIO_EN     fixed priority, A always beats B, no FSM
//
//   FSM (round-robin build only):
//     state  | meaning
//     LAST_A | A held the most recent grant, so B wins a tie
//     LAST_B | B held the most recent grant (or reset), so A wins a tie
//
// Ports
//   clk                  rising-edge clock
//   rst                  synchronous active-high reset
//   a_valid/a_ready      requester A (ALU writeback) handshake
//   a_addr/a_data        requester A destination register and data
//   b_valid/b_ready      requester B (memory-load writeback) handshake
//   b_addr/b_data        requester B destination register and data
//   RegWrite             registered bank write strobe
//   AW/Di                registered bank write address and data
//   src_b                registered; the current RegWrite came from B
module reg_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] AW,
    output logic [DATA_W-1:0] Di,
    output logic              src_b
);

    logic              a_full_q, a_full_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic [DATA_W-1:0] a_data_q, a_data_d;
    logic              b_full_q, b_full_d;
    logic [ADDR_W-1:0] b_addr_q, b_addr_d;
    logic [DATA_W-1:0] b_data_q, b_data_d;

    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] aw_q, aw_d;
    logic [DATA_W-1:0] di_q, di_d;
    logic              src_b_q, src_b_d;

    logic              a_win, b_win;

`ifdef WB_STRICT_PRIO_EN
    always_comb begin
        a_win = a_full_q;
        b_win = b_full_q & ~a_full_q;
    end
`else
    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } arb_state_e;

    arb_state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LAST_B;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (a_win) begin
            state_d = LAST_A;
        end else if (b_win) begin
            state_d = LAST_B;
        end
    end

    always_comb begin
        a_win = a_full_q & (~b_full_q | (state_q == LAST_B));
        b_win = b_full_q & (~a_full_q | (state_q == LAST_A));
    end
`endif

    // A buffer that is being drained this cycle can take a new entry at the
    // same edge. This is what lets a single requester sustain one write per
    // cycle.
    assign a_ready = (~a_full_q | a_win) & ~rst;
    assign b_ready = (~b_full_q | b_win) & ~rst;

    always_comb begin
        a_full_d = (a_full_q & ~a_win) | (a_valid & a_ready);
        a_addr_d = a_addr_q;
        a_data_d = a_data_q;
        if (a_valid && a_ready) begin
            a_addr_d = a_addr;
            a_data_d = a_data;
        end

        b_full_d = (b_full_q & ~b_win) | (b_valid & b_ready);
        b_addr_d = b_addr_q;
        b_data_d = b_data_q;
        if (b_valid && b_ready) begin
            b_addr_d = b_addr;
            b_data_d = b_data;
        end
    end

    // A granted write to r0 still frees its buffer and takes the slot.
    // It leaves the whole write port untouched apart from dropping RegWrite.
    always_comb begin
        reg_write_d = 1'b0;
        aw_d        = aw_q;
        di_d        = di_q;
        src_b_d     = src_b_q;
        if (b_win && (b_addr_q != '0)) begin
            reg_write_d = 1'b1;
            aw_d        = b_addr_q;
            di_d        = b_data_q;
            src_b_d     = 1'b1;
        end else if (a_win && (a_addr_q != '0)) begin
            reg_write_d = 1'b1;
            aw_d        = a_addr_q;
            di_d        = a_data_q;
            src_b_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_full_q    <= 1'b0;
            a_addr_q    <= '0;
            a_data_q    <= '0;
            b_full_q    <= 1'b0;
            b_addr_q    <= '0;
            b_data_q    <= '0;
            reg_write_q <= 1'b0;
            aw_q        <= '0;
            di_q        <= '0;
            src_b_q     <= 1'b0;
        end else begin
            a_full_q    <= a_full_d;
            a_addr_q    <= a_addr_d;
            a_data_q    <= a_data_d;
            b_full_q    <= b_full_d;
            b_addr_q    <= b_addr_d;
            b_data_q    <= b_data_d;
            reg_write_q <= reg_write_d;
            aw_q        <= aw_d;
            di_q        <= di_d;
            src_b_q     <= src_b_d;
        end
    end

    assign RegWrite = reg_write_q;
    assign AW       = aw_q;
    assign Di       = di_q;
    assign src_b    = src_b_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Testbench for reg_wb_arbiter.
//   Directed table of per-cycle vectors, followed by hand-written streaming
//   and contention sequences. Build with +define+WB_STRICT_PRIO_EN to check
//   the fixed-priority variant.
module tb_reg_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        RegWrite;
    logic [4:0]  AW;
    logic [31:0] Di;
    logic        src_b;

    int total = 0;
    int bad   = 0;

    reg_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .RegWrite (RegWrite),
        .AW       (AW),
        .Di       (Di),
        .src_b    (src_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        e_ar;
        logic        e_br;
        logic        e_rw;
        logic [4:0]  e_aw;
        logic [31:0] e_di;
        logic        e_sb;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    function automatic vec_t mk(logic r, logic av, logic [4:0] aa, logic [31:0] ad,
                                logic bv, logic [4:0] ba, logic [31:0] bd,
                                logic ear, logic ebr, logic erw, logic [4:0] eaw,
                                logic [31:0] edi, logic esb);
        vec_t v;
        v.rst = r;  v.av = av; v.aa = aa; v.ad = ad;
        v.bv = bv;  v.ba = ba; v.bd = bd;
        v.e_ar = ear; v.e_br = ebr; v.e_rw = erw;
        v.e_aw = eaw; v.e_di = edi; v.e_sb = esb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expectations are sampled 1 time unit after the negedge. Outputs reflect
    // edges already taken, and ready reflects the buffer state before the
    // coming edge.
    initial begin
        //            rst av aa  ad     bv ba  bd            ar br rw aw  di      sb
        vecs[0]  = mk(1, 0, 0,  0,     0, 0,  0,            0, 0, 0, 0,  0,      0);
        vecs[1]  = mk(0, 1, 3,  'hAA,  0, 0,  0,            1, 1, 0, 0,  0,      0);
        vecs[2]  = mk(0, 0, 0,  0,     0, 0,  0,            1, 1, 0, 0,  0,      0);
        vecs[3]  = mk(0, 0, 0,  0,     0, 0,  0,            1, 1, 1, 3,  'hAA,   0);
        vecs[4]  = mk(1, 0, 0,  0,     0, 0,  0,            0, 0, 0, 3,  'hAA,   0);
        vecs[5]  = mk(0, 1, 5,  'h11,  1, 6,  'h22,         1, 1, 0, 0,  0,      0);
        vecs[6]  = mk(0, 0, 0,  0,     0, 0,  0,            1, 0, 0, 0,  0,      0);
        vecs[7]  = mk(0, 0, 0,  0,     0, 0,  0,            1, 1, 1, 5,  'h11,   0);
        vecs[8]  = mk(0, 0, 0,  0,     0, 0,  0,            1, 1, 1, 6,  'h22,   1);
        vecs[9]  = mk(0, 0, 0,  0,     1, 0,  'hFFFF_FFFF,  1, 1, 0, 6,  'h22,   1);
        vecs[10] = mk(0, 0, 0,  0,     1, 9,  'h99,         1, 1, 0, 6,  'h22,   1);
        vecs[11] = mk(0, 0, 0,  0,     0, 0,  0,            1, 1, 0, 6,  'h22,   1);
        vecs[12] = mk(0, 0, 0,  0,     0, 0,  0,            1, 1, 1, 9,  'h99,   1);
        vecs[13] = mk(0, 1, 7,  'h1,   1, 7,  'h2,          1, 1, 0, 9,  'h99,   1);
        vecs[14] = mk(0, 0, 0,  0,     0, 0,  0,            1, 0, 0, 9,  'h99,   1);
        vecs[15] = mk(0, 0, 0,  0,     0, 0,  0,            1, 1, 1, 7,  'h1,    0);
        vecs[16] = mk(0, 0, 0,  0,     0, 0,  0,            1, 1, 1, 7,  'h2,    1);
        vecs[17] = mk(0, 1, 10, 'hA0,  1, 11, 'hB0,         1, 1, 0, 7,  'h2,    1);
        vecs[18] = mk(1, 0, 0,  0,     0, 0,  0,            0, 0, 0, 7,  'h2,    1);
        vecs[19] = mk(0, 0, 0,  0,     0, 0,  0,            1, 1, 0, 0,  0,      0);
        vecs[20] = mk(0, 0, 0,  0,     0, 0,  0,            1, 1, 0, 0,  0,      0);
    end

    initial begin
        int a_list [4];
        int exp_ord [5];
        int ai;
        int n;

        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        a_addr = '0; a_data = '0; b_addr = '0; b_data = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst     = vecs[i].rst;
            a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
            b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
            #1;
            chk($sformatf("v%0d a_ready", i),  32'(a_ready),  32'(vecs[i].e_ar));
            chk($sformatf("v%0d b_ready", i),  32'(b_ready),  32'(vecs[i].e_br));
            chk($sformatf("v%0d RegWrite", i), 32'(RegWrite), 32'(vecs[i].e_rw));
            chk($sformatf("v%0d AW", i),       32'(AW),       32'(vecs[i].e_aw));
            chk($sformatf("v%0d Di", i),       Di,            vecs[i].e_di);
            chk($sformatf("v%0d src_b", i),    32'(src_b),    32'(vecs[i].e_sb));
        end

        // Streaming: A offers r1..r8 back to back.
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            rst = 1'b0; b_valid = 1'b0;
            a_valid = (c < 8);
            a_addr  = 5'(c + 1);
            a_data  = 32'h100 + 32'(c + 1);
            #1;
            if (c < 8) chk($sformatf("stream c%0d a_ready", c), 32'(a_ready), 32'd1);
            if (c >= 2 && c < 10) begin
                chk($sformatf("stream c%0d RegWrite", c), 32'(RegWrite), 32'd1);
                chk($sformatf("stream c%0d AW", c), 32'(AW), 32'(c - 1));
                chk($sformatf("stream c%0d Di", c), Di, 32'h100 + 32'(c - 1));
            end else begin
                chk($sformatf("stream c%0d RegWrite", c), 32'(RegWrite), 32'd0);
            end
        end

        // Contention: B posts once while A keeps refilling. A holds each
        // request until it is accepted. The last grant before this point was
        // A's, so round-robin serves B first.
        a_list = '{12, 14, 15, 16};
`ifdef WB_STRICT_PRIO_EN
        exp_ord = '{12, 14, 15, 16, 13};
`else
        exp_ord = '{13, 12, 14, 15, 16};
`endif
        ai = 0;
        n  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            a_valid = (ai < 4);
            a_addr  = (ai < 4) ? 5'(a_list[ai]) : 5'd0;
            a_data  = (ai < 4) ? 32'h1000 + 32'(a_list[ai]) : 32'd0;
            b_valid = (c == 0);
            b_addr  = 5'd13;
            b_data  = 32'h1000 + 32'd13;
            #1;
            if (c == 0) chk("contend b_ready", 32'(b_ready), 32'd1);
            if (RegWrite) begin
                if (n < 5) begin
                    chk($sformatf("contend grant%0d AW", n), 32'(AW), 32'(exp_ord[n]));
                    chk($sformatf("contend grant%0d Di", n), Di, 32'h1000 + 32'(exp_ord[n]));
                    chk($sformatf("contend grant%0d src_b", n), 32'(src_b),
                        32'(exp_ord[n] == 13));
                end else begin
                    total++;
                    bad++;
                    $display("FAIL contend extra write: AW=%0d beyond expected 5 grants", AW);
                end
                n++;
            end
            if (a_valid && a_ready) ai++;
        end
        chk("contend grant count", 32'(n), 32'd5);
        chk("contend A all accepted", 32'(ai), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
